// File: rtl/shift_cmd_sequencer.sv
// Command FIFO feeding an 8-bit barrel shifter in passes of <=7. Result valid 1+ceil(amt/7) cycles after pop and held until res_ready.
// cmd_ready drops while the FIFO is full. Define SEQ_SATURATE_EN to resolve amounts >= 8 to zero at pop without driving the shifter.

module shift_cmd_fifo #(
   parameter int W     = 13,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_dat,
   output logic [W-1:0] o_dat,
   output logic         o_full,
   output logic         o_empty
);
   localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   // A pop never frees space for a push in the same cycle.
   assign o_full  = (r_count == L_FULL);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_dat   = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end
endmodule

module shift_cmd_sequencer #(
   parameter int DATA_W     = 8,
   parameter int AMT_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [DATA_W-1:0] i_cmd_data,
   input  logic [AMT_W-1:0]  i_cmd_amt,
   input  logic              i_cmd_dir,
   output logic [DATA_W-1:0] o_sh_x,
   output logic [2:0]        o_sh_sel,
   output logic              o_sh_cntrl,
   input  logic [DATA_W-1:0] i_sh_z,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [DATA_W-1:0] o_res_data,
   output logic              o_busy
);
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
      logic              dir;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [AMT_W-1:0] L_MAX_STEP = AMT_W'(7);
`ifdef SEQ_SATURATE_EN
   localparam logic [AMT_W-1:0] L_SAT_AMT  = AMT_W'(8);
`endif

   function automatic logic [2:0] f_step(input logic [AMT_W-1:0] a);
      return (a > L_MAX_STEP) ? 3'd7 : a[2:0];
   endfunction

   cmd_t             w_fifo_in;
   cmd_t             w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic [AMT_W-1:0] w_rem_nxt;

   state_t           r_state;
   logic [AMT_W-1:0] r_rem;
   logic [DATA_W-1:0] r_sh_x;
   logic [2:0]       r_sh_sel;
   logic             r_sh_cntrl;
   logic             r_res_valid;
   logic [DATA_W-1:0] r_res_data;

   assign w_fifo_in = '{data: i_cmd_data, amt: i_cmd_amt, dir: i_cmd_dir};
   assign w_pop     = (r_state == S_IDLE) && !w_empty;
   assign w_rem_nxt = r_rem - AMT_W'(f_step(r_rem));

   shift_cmd_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_cmd_valid),
      .i_pop   (w_pop),
      .i_dat   (w_fifo_in),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_cmd_ready = !w_full;
   assign o_busy      = (r_state != S_IDLE) || !w_empty;
   assign o_sh_x      = r_sh_x;
   assign o_sh_sel    = r_sh_sel;
   assign o_sh_cntrl  = r_sh_cntrl;
   assign o_res_valid = r_res_valid;
   assign o_res_data  = r_res_data;

   // r_sh_x doubles as the accumulator and r_sh_cntrl as the direction while shifting.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_sh_x      <= '0;
         r_sh_sel    <= '0;
         r_sh_cntrl  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_rem <= w_head.amt;
`ifdef SEQ_SATURATE_EN
                  if (w_head.amt >= L_SAT_AMT) begin
                     r_rem       <= '0;
                     r_state     <= S_DONE;
                     r_res_valid <= 1'b1;
                     r_res_data  <= '0;
                  end else
`endif
                  if (w_head.amt == '0) begin
                     r_state     <= S_DONE;
                     r_res_valid <= 1'b1;
                     r_res_data  <= w_head.data;
                  end else begin
                     r_state    <= S_SHIFT;
                     r_sh_x     <= w_head.data;
                     r_sh_sel   <= f_step(w_head.amt);
                     r_sh_cntrl <= w_head.dir;
                  end
               end
            end
            S_SHIFT: begin
               r_rem <= w_rem_nxt;
               if (w_rem_nxt == '0) begin
                  r_state     <= S_DONE;
                  r_res_valid <= 1'b1;
                  r_res_data  <= i_sh_z;
                  r_sh_x      <= '0;
                  r_sh_sel    <= '0;
                  r_sh_cntrl  <= 1'b0;
               end else begin
                  r_sh_x   <= i_sh_z;
                  r_sh_sel <= f_step(w_rem_nxt);
               end
            end
            S_DONE: begin
               if (i_res_ready) begin
                  r_state     <= S_IDLE;
                  r_res_valid <= 1'b0;
                  r_res_data  <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer; the bench itself plays the barrel shifter.
module tb_shift_cmd_sequencer;
   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [3:0] cmd_amt;
   logic       cmd_dir;
   logic [7:0] sh_x;
   logic [2:0] sh_sel;
   logic       sh_cntrl;
   logic [7:0] sh_z;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   logic [2:0] sel_seen[$];
   logic [7:0] x_seen[$];
   logic       cntrl_seen[$];
   logic       sh_any;

   logic [7:0] tv_d[4]   = '{8'h80, 8'hFF, 8'hFF, 8'h5A};
   logic [3:0] tv_a[4]   = '{4'd7,  4'd15, 4'd8,  4'd14};
   logic       tv_dir[4] = '{1'b1,  1'b1,  1'b1,  1'b0};

   logic [7:0] t5_d[5]   = '{8'hAD, 8'h3C, 8'hF0, 8'h01, 8'h99};
   logic [3:0] t5_a[5]   = '{4'd2,  4'd1,  4'd4,  4'd7,  4'd0};
   logic       t5_dir[5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

   shift_cmd_sequencer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_data  (cmd_data),
      .i_cmd_amt   (cmd_amt),
      .i_cmd_dir   (cmd_dir),
      .o_sh_x      (sh_x),
      .o_sh_sel    (sh_sel),
      .o_sh_cntrl  (sh_cntrl),
      .i_sh_z      (sh_z),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_data  (res_data),
      .o_busy      (busy)
   );

   assign sh_z = sh_cntrl ? (sh_x >> sh_sel) : (sh_x << sh_sel);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of run, required finish");
      $fatal(1);
   end

   function automatic logic [7:0] f_ref(input logic [7:0] d, input logic [3:0] a, input logic dir);
      logic [7:0] r;
      if (a >= 4'd8)  r = 8'h00;
      else if (dir)   r = d >> a;
      else            r = d << a;
      return r;
   endfunction

   function automatic int f_lat(input logic [3:0] a);
`ifdef SEQ_SATURATE_EN
      if (a >= 4'd8) return 1;
`endif
      if (a == 4'd0)  return 1;
      if (a <= 4'd7)  return 2;
      if (a <= 4'd14) return 3;
      return 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
   endtask

   task automatic push_cmd(input logic [7:0] d, input logic [3:0] a, input logic dir);
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_amt   = a;
      cmd_dir   = dir;
      exp_q.push_back(f_ref(d, a, dir));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Starts in the pop cycle; counts cycles until res_valid, then handshakes.
   task automatic collect(input string tag, input int exp_lat);
      int         lat;
      logic [7:0] expv;
      lat = 0;
      sh_any = 1'b0;
      sel_seen.delete();
      x_seen.delete();
      cntrl_seen.delete();
      while (!res_valid && lat < 64) begin
         sh_any = sh_any | (sh_x != 8'h00) | (sh_sel != 3'd0) | sh_cntrl;
         if (sh_sel != 3'd0) begin
            sel_seen.push_back(sh_sel);
            x_seen.push_back(sh_x);
            cntrl_seen.push_back(sh_cntrl);
         end
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk({tag, "_data"}, res_data, expv);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_busy_after"}, busy, 1'b0);
   endtask

   initial begin
      int got;
      int cyc;
      int stale;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_amt   = 4'd0;
      cmd_dir   = 1'b0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data",  res_data,  8'h00);
      chk("rst_sh_x",      sh_x,      8'h00);
      chk("rst_sh_sel",    sh_sel,    3'd0);
      chk("rst_sh_cntrl",  sh_cntrl,  1'b0);
      chk("rst_busy",      busy,      1'b0);
      rst = 1'b0;
      @(negedge clk);

      push_cmd(8'b10101101, 4'd3, 1'b0);
      chk("t1_busy", busy, 1'b1);
      collect("t1", 2);
      chk("t1_passes", sel_seen.size(), 1);
      chk("t1_sel", sel_seen[0], 3'd3);
      chk("t1_x", x_seen[0], 8'hAD);
      chk("t1_cntrl", cntrl_seen[0], 1'b0);

      push_cmd(8'b10101101, 4'd3, 1'b1);
      collect("t2", 2);
      chk("t2_cntrl", cntrl_seen[0], 1'b1);

      push_cmd(8'hFF, 4'd9, 1'b0);
      collect("t3", f_lat(4'd9));
`ifdef SEQ_SATURATE_EN
      chk("t3_passes", sel_seen.size(), 0);
`else
      chk("t3_passes", sel_seen.size(), 2);
      chk("t3_sel0", sel_seen[0], 3'd7);
      chk("t3_sel1", sel_seen[1], 3'd2);
      chk("t3_acc1", x_seen[1], 8'h80);
`endif

      push_cmd(8'h81, 4'd0, 1'b0);
      collect("t4", 1);
      chk("t4_sh_quiet", sh_any, 1'b0);

      for (int i = 0; i < 4; i++) begin
         push_cmd(tv_d[i], tv_a[i], tv_dir[i]);
         collect($sformatf("tv%0d", i), f_lat(tv_a[i]));
      end

      // Stall the output while five commands arrive back-to-back.
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_ready%0d", i), cmd_ready, 1'b1);
         cmd_valid = 1'b1;
         cmd_data  = t5_d[i];
         cmd_amt   = t5_a[i];
         cmd_dir   = t5_dir[i];
         exp_q.push_back(f_ref(t5_d[i], t5_a[i], t5_dir[i]));
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("t5_full", cmd_ready, 1'b0);
      chk("t5_stall_valid", res_valid, 1'b1);
      chk("t5_stall_data0", res_data, exp_q[0]);
      repeat (3) @(negedge clk);
      chk("t5_stall_data1", res_data, exp_q[0]);
      chk("t5_still_full", cmd_ready, 1'b0);
      res_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 5 && cyc < 200) begin
         if (res_valid) begin
            chk($sformatf("t5_drain%0d", got), res_data, exp_q.pop_front());
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      res_ready = 1'b0;
      chk("t5_drain_count", got, 5);
      @(negedge clk);
      chk("t5_busy_end", busy, 1'b0);
      chk("t5_ready_end", cmd_ready, 1'b1);

      // Reset while a 15-bit shift is in flight with two commands behind it.
      exp_q.delete();
      cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_amt = 4'd15; cmd_dir = 1'b0;
      @(negedge clk);
      cmd_data = 8'h11; cmd_amt = 4'd1;
      @(negedge clk);
      cmd_data = 8'h22; cmd_amt = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("t6_busy_pre", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_res_valid", res_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_cmd_ready", cmd_ready, 1'b1);
      chk("t6_sh_sel", sh_sel, 3'd0);
      stale = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid || busy) stale++;
      end
      chk("t6_no_stale", stale, 0);

      push_cmd(8'h0F, 4'd4, 1'b0);
      collect("t7", 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
